sigma_delta_modulator: RTL and testbench

SIGMA_DELTA_MODULATOR -- requirements
Module: sigma_delta_modulator

---
 rtl/sigma_delta_modulator.sv | 183 ++++++++++++++++++
 tb/tb_sigma_delta_modulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_modulator.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_modulator
// Purpose  : Dual-channel second-order 1-bit sigma-delta modulator fed from a
//            one-entry sample buffer. Optional LFSR dither: SIGMA_DELTA_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_delta_modulator #(
  parameter int OSR_LOG2  = 6,
  parameter int INT_WIDTH = 28
) (
  input  logic        clock_200,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  rate_div,
  input  logic [47:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        overflow_clear,
  output logic        sigma_delta_stream_A,
  output logic        sigma_delta_stream_B,
  output logic        sample_trigger,
  output logic        overflow_A,
  output logic        overflow_B,
  output logic        underrun
);

  localparam int c_SUM_W  = INT_WIDTH + 2;
  localparam int c_STEP_W = 2 * INT_WIDTH + 2;
  localparam logic signed [INT_WIDTH-1:0] c_SAT_MAX  = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] c_SAT_MIN  = -c_SAT_MAX;
  localparam logic signed [c_SUM_W-1:0]   c_SUM_MAX  = {2'b00, c_SAT_MAX};
  localparam logic signed [c_SUM_W-1:0]   c_SUM_MIN  = -c_SUM_MAX;
  localparam logic signed [c_SUM_W-1:0]   c_FB_POS   = c_SUM_W'(32'sh0080_0000);
  localparam logic [OSR_LOG2-1:0]         c_CNT_LAST = {OSR_LOG2{1'b1}};

  // One loop iteration; packed result is {ovf, new_bit, i2, i1}.
  // Both integrators run with two guard bits so saturation is detected exactly.
  function automatic logic [c_STEP_W-1:0] loop_step(
    input logic signed [23:0]          x,
    input logic signed [INT_WIDTH-1:0] i1,
    input logic signed [INT_WIDTH-1:0] i2,
    input logic                        bit_q,
    input logic signed [c_SUM_W-1:0]   dither
  );
    logic signed [c_SUM_W-1:0]   fb;
    logic signed [c_SUM_W-1:0]   s1;
    logic signed [c_SUM_W-1:0]   s2;
    logic signed [INT_WIDTH-1:0] i1_n;
    logic signed [INT_WIDTH-1:0] i2_n;
    logic                        ovf;
    fb  = bit_q ? c_FB_POS : -c_FB_POS;
    ovf = 1'b0;
    s1  = {{2{i1[INT_WIDTH-1]}}, i1} + {{(c_SUM_W-24){x[23]}}, x} - fb;
    if (s1 > c_SUM_MAX) begin
      i1_n = c_SAT_MAX;
      ovf  = 1'b1;
    end else if (s1 < c_SUM_MIN) begin
      i1_n = c_SAT_MIN;
      ovf  = 1'b1;
    end else begin
      i1_n = s1[INT_WIDTH-1:0];
    end
    s2 = {{2{i2[INT_WIDTH-1]}}, i2} + {{2{i1_n[INT_WIDTH-1]}}, i1_n} - fb + dither;
    if (s2 > c_SUM_MAX) begin
      i2_n = c_SAT_MAX;
      ovf  = 1'b1;
    end else if (s2 < c_SUM_MIN) begin
      i2_n = c_SAT_MIN;
      ovf  = 1'b1;
    end else begin
      i2_n = s2[INT_WIDTH-1:0];
    end
    return {ovf, ~i2_n[INT_WIDTH-1], i2_n, i1_n};
  endfunction

  logic [7:0]                  r_div;
  logic [OSR_LOG2-1:0]         r_cnt;
  logic [47:0]                 r_buf;
  logic                        r_buf_full;
  logic signed [23:0]          r_act [2];
  logic signed [INT_WIDTH-1:0] r_i1  [2];
  logic signed [INT_WIDTH-1:0] r_i2  [2];
  logic [1:0]                  r_bit;
  logic                        r_trig;
  logic                        r_ovf_a;
  logic                        r_ovf_b;
  logic                        r_underrun;

  logic                        w_tick;
  logic                        w_boundary;
  logic                        w_accept;
  logic signed [c_SUM_W-1:0]   w_dither;
  logic [c_STEP_W-1:0]         w_step [2];

  assign w_tick       = enable && (r_div == 8'd0);
  assign w_boundary   = w_tick && (r_cnt == c_CNT_LAST);
  assign sample_ready = !r_buf_full;
  assign w_accept     = sample_valid && sample_ready;

`ifdef SIGMA_DELTA_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clock_200 or negedge reset) begin
    if (!reset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_tick) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_dither = {{(c_SUM_W-4){r_lfsr[3]}}, r_lfsr[3:0]};
`else
  assign w_dither = '0;
`endif

  // Channel 0 is A (sample_in[47:24]), channel 1 is B (sample_in[23:0]).
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_step[ch] = loop_step(r_act[ch], r_i1[ch], r_i2[ch], r_bit[ch], w_dither);
    end
  end

  always_ff @(posedge clock_200 or negedge reset) begin
    if (!reset) begin
      r_div      <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_bit      <= '0;
      r_trig     <= 1'b0;
      r_ovf_a    <= 1'b0;
      r_ovf_b    <= 1'b0;
      r_underrun <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        r_act[ch] <= '0;
        r_i1[ch]  <= '0;
        r_i2[ch]  <= '0;
      end
    end else begin
      r_trig <= w_boundary;

      if (enable) begin
        r_div <= (r_div == 8'd0) ? rate_div : r_div - 8'd1;
      end

      if (w_tick) begin
        r_cnt <= r_cnt + OSR_LOG2'(1);
        for (int ch = 0; ch < 2; ch++) begin
          r_i1[ch]  <= w_step[ch][INT_WIDTH-1:0];
          r_i2[ch]  <= w_step[ch][2*INT_WIDTH-1:INT_WIDTH];
          r_bit[ch] <= w_step[ch][c_STEP_W-2];
        end
      end

      if (w_boundary && r_buf_full) begin
        r_act[0] <= r_buf[47:24];
        r_act[1] <= r_buf[23:0];
      end

      // A full buffer blocks accepts, so accept and load are mutually exclusive.
      if (w_accept) begin
        r_buf      <= sample_in;
        r_buf_full <= 1'b1;
      end else if (w_boundary) begin
        r_buf_full <= 1'b0;
      end

      r_ovf_a    <= (w_tick && w_step[0][c_STEP_W-1]) || (r_ovf_a && !overflow_clear);
      r_ovf_b    <= (w_tick && w_step[1][c_STEP_W-1]) || (r_ovf_b && !overflow_clear);
      r_underrun <= (w_boundary && !r_buf_full) || (r_underrun && !overflow_clear);
    end
  end

  assign sigma_delta_stream_A = r_bit[0];
  assign sigma_delta_stream_B = r_bit[1];
  assign sample_trigger       = r_trig;
  assign overflow_A           = r_ovf_a;
  assign overflow_B           = r_ovf_b;
  assign underrun             = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigma_delta_modulator
// Purpose  : Directed self-checking bench for sigma_delta_modulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_modulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  rate_div;
  logic [47:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        overflow_clear;
  logic        str_a;
  logic        str_b;
  logic        trig;
  logic        ovf_a;
  logic        ovf_b;
  logic        urun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sigma_delta_modulator dut (
    .clock_200            (clk),
    .reset                (rst_n),
    .enable               (enable),
    .rate_div             (rate_div),
    .sample_in            (sample_in),
    .sample_valid         (sample_valid),
    .sample_ready         (sample_ready),
    .overflow_clear       (overflow_clear),
    .sigma_delta_stream_A (str_a),
    .sigma_delta_stream_B (str_b),
    .sample_trigger       (trig),
    .overflow_A           (ovf_a),
    .overflow_B           (ovf_b),
    .underrun             (urun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    total++;
    assert (val >= lo && val <= hi) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic do_reset(input logic [7:0] rd, input logic [47:0] s, input logic v);
    @(negedge clk);
    rst_n          = 1'b0;
    enable         = 1'b1;
    overflow_clear = 1'b0;
    rate_div       = rd;
    sample_in      = s;
    sample_valid   = v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_bits(input int n, output int a, output int b);
    a = 0;
    b = 0;
    repeat (n) begin
      @(negedge clk);
      a += str_a ? 1 : 0;
      b += str_b ? 1 : 0;
    end
  endtask

  // Bounded wait for sample_trigger; n is the negedge index it was seen on.
  task automatic wait_trig(output int n, output int ones_a, output int ready_hi);
    n        = 0;
    ones_a   = 0;
    ready_hi = 0;
    do begin
      @(negedge clk);
      n++;
      ones_a += str_a ? 1 : 0;
      if (sample_ready && !trig) ready_hi++;
    end while (!trig && n < 600);
  endtask

  initial begin
    int   a, b, n, rh, changes;
    logic hold;

    rst_n          = 1'b0;
    enable         = 1'b1;
    rate_div       = 8'd0;
    sample_in      = '0;
    sample_valid   = 1'b0;
    overflow_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stream_a", str_a, 0);
    check("rst_stream_b", str_b, 0);
    check("rst_trigger", trig, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_ovf_b", ovf_b, 0);
    check("rst_underrun", urun, 0);

    // Zero input, buffer kept fed: balanced streams, no flags.
    do_reset(8'd0, 48'h0, 1'b1);
    count_bits(256, a, b);
    check_range("zero_ones_a", a, 126, 130);
    check_range("zero_ones_b", b, 126, 130);
    check("zero_ovf_a", ovf_a, 0);
    check("zero_ovf_b", ovf_b, 0);
    check("zero_underrun", urun, 0);

    // +half on A, -half on B.
    do_reset(8'd0, {24'h400000, 24'hC00000}, 1'b1);
    repeat (128) @(negedge clk);
    count_bits(1024, a, b);
    check_range("half_ones_a", a, 764, 772);
    check_range("half_ones_b", b, 252, 260);
    check("half_ovf_a", ovf_a, 0);
    check("half_ovf_b", ovf_b, 0);

    // rate_div=3, nothing supplied: frame every 256 clocks, underrun.
    do_reset(8'd3, 48'h0, 1'b0);
    wait_trig(n, a, rh);
    check("starve_first_trig", n, 253);
    check("starve_underrun", urun, 1);
    @(negedge clk);
    check("starve_trig_pulse", trig, 0);
    wait_trig(n, a, rh);
    check("starve_trig_period", n, 255);
    check_range("starve_ones_a", a, 120, 136);
    check("starve_underrun_held", urun, 1);

    // Back-to-back samples: second one waits for the boundary.
    do_reset(8'd0, 48'h0, 1'b0);
    sample_in    = {24'h400000, 24'hC00000};
    sample_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_accept", sample_ready, 0);
    sample_in = {24'hC00000, 24'h400000};
    wait_trig(n, a, rh);
    check("b2b_load_time", n, 63);
    check("b2b_ready_held_low", rh, 0);
    check("b2b_ready_at_load", sample_ready, 1);
    @(negedge clk);
    check("b2b_second_accept", sample_ready, 0);
    sample_valid = 1'b0;
    wait_trig(n, a, rh);
    check("b2b_frame2_len", n, 63);
    check_range("b2b_frame2_ones_a", a, 36, 60);
    check("b2b_frame2_underrun", urun, 0);
    wait_trig(n, a, rh);
    check("b2b_frame3_len", n, 64);
    check_range("b2b_frame3_ones_a", a, 4, 28);
    check("b2b_frame3_underrun", urun, 1);

    // Full-scale A saturates; clear loses to a concurrent set.
    do_reset(8'd0, {24'h7FFFFF, 24'h000000}, 1'b1);
    repeat (64 + 1024) @(negedge clk);
    check("fs_ovf_a", ovf_a, 1);
    check("fs_ovf_b", ovf_b, 0);
    check("fs_underrun", urun, 0);
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    check("fs_set_wins", ovf_a, 1);
    sample_in = 48'h0;
    repeat (200) @(negedge clk);
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    check("fs_cleared", ovf_a, 0);
    repeat (256) @(negedge clk);
    check("fs_stays_clear_a", ovf_a, 0);
    check("fs_stays_clear_b", ovf_b, 0);

    // Reset mid-frame with a full buffer: buffer discarded, fresh frame.
    do_reset(8'd0, {24'h400000, 24'hC00000}, 1'b1);
    repeat (30) @(negedge clk);
    check("mid_buf_full", sample_ready, 0);
    sample_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("mid_rst_stream_a", str_a, 0);
    check("mid_rst_stream_b", str_b, 0);
    check("mid_rst_trigger", trig, 0);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_underrun", urun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_trig(n, a, rh);
    check("mid_next_trig", n, 64);
    check("mid_buffer_discarded", urun, 1);

    // enable=0 freezes divider, frame counter and streams.
    do_reset(8'd0, 48'h0, 1'b0);
    repeat (10) @(negedge clk);
    enable  = 1'b0;
    hold    = str_a;
    changes = 0;
    repeat (20) begin
      @(negedge clk);
      if (str_a !== hold) changes++;
    end
    check("freeze_stream_hold", changes, 0);
    enable = 1'b1;
    wait_trig(n, a, rh);
    check("freeze_trig_delay", n, 54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
